// File: rtl/xnor_compare_sched.sv
// rtl/xnor_compare_sched.sv - round-robin scheduler sharing one NAND-built XNOR cell for bit-serial word compare
module xnor_compare_sched #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output logic [WIDTH-1:0] resp_mask,
  output logic             resp_eq,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_RESP  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             id_q, id_d;

  logic grant;
  logic accept;
  logic last_bit;

  // Shared equality cell, NAND gates only
  logic cell_x, cell_y, cell_na, cell_nb, cell_nxy, cell_nab, cell_out;

  assign cell_x   = a_sh_q[0];
  assign cell_y   = b_sh_q[0];
  assign cell_na  = ~(cell_x & cell_x);
  assign cell_nb  = ~(cell_y & cell_y);
  assign cell_nxy = ~(cell_x & cell_y);
  assign cell_nab = ~(cell_na & cell_nb);
  assign cell_out = ~(cell_nxy & cell_nab);

  // Grant the lone valid requester, or the priority one when both are valid
  always_comb begin
    grant    = (req0_valid && req1_valid) ? prio_q : req1_valid;
    accept   = (state_q == S_IDLE) && (req0_valid || req1_valid);
    last_bit = (cnt_q == CW'(WIDTH - 1));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: accept -> WIDTH shift cycles -> hold response until taken
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept)     state_d = S_SHIFT;
      S_SHIFT: if (last_bit)   state_d = S_RESP;
      S_RESP:  if (resp_ready) state_d = S_IDLE;
      default:                 state_d = S_IDLE;
    endcase
  end

  // Outputs: readies only in IDLE and never while reset is held
  always_comb begin
    req0_ready = rst_n && (state_q == S_IDLE) && req0_valid && !grant;
    req1_ready = rst_n && (state_q == S_IDLE) && req1_valid && grant;
    resp_valid = (state_q == S_RESP);
    busy       = (state_q != S_IDLE);
    resp_id    = id_q;
    resp_mask  = mask_q;
    resp_eq    = &mask_q;
  end

  // Datapath next values: latch operands on accept, build mask one bit per SHIFT cycle
  always_comb begin
    prio_d = prio_q;
    cnt_d  = cnt_q;
    a_sh_d = a_sh_q;
    b_sh_d = b_sh_q;
    mask_d = mask_q;
    id_d   = id_q;
    if (state_q == S_IDLE) begin
      if (accept) begin
        a_sh_d = grant ? req1_a : req0_a;
        b_sh_d = grant ? req1_b : req0_b;
        id_d   = grant;
        mask_d = '0;
        cnt_d  = '0;
        prio_d = ~grant;
      end
    end else if (state_q == S_SHIFT) begin
      mask_d[cnt_q] = cell_out;
      a_sh_d        = a_sh_q >> 1;
      b_sh_d        = b_sh_q >> 1;
      cnt_d         = last_bit ? '0 : cnt_q + CW'(1);
    end
  end

  // Datapath registers; reset drops any in-flight request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
      cnt_q  <= '0;
      a_sh_q <= '0;
      b_sh_q <= '0;
      mask_q <= '0;
      id_q   <= 1'b0;
    end else begin
      prio_q <= prio_d;
      cnt_q  <= cnt_d;
      a_sh_q <= a_sh_d;
      b_sh_q <= b_sh_d;
      mask_q <= mask_d;
      id_q   <= id_d;
    end
  end

endmodule

// File: tb/tb_xnor_compare_sched.sv
// tb/tb_xnor_compare_sched.sv - self-checking bench for xnor_compare_sched
module tb_xnor_compare_sched;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req0_valid, req1_valid;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic             req0_ready, req1_ready;
  logic             resp_valid, resp_ready, resp_id, resp_eq, busy;
  logic [WIDTH-1:0] resp_mask;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  bit         log_id[$];
  logic [7:0] log_mask[$];
  bit         log_eq[$];

  xnor_compare_sched #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_mask(resp_mask), .resp_eq(resp_eq), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: phase 0 = waiting for a request, 1 = comparing, 2 = offering response
  int         m_phase = 0;
  int         m_left  = 0;
  bit         m_prio  = 0;
  bit         m_id    = 0;
  logic [7:0] m_mask  = '0;

  initial begin
    bit exp_r0, exp_r1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_r0", req0_ready, 0);
        check("rst_r1", req1_ready, 0);
        check("rst_valid", resp_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_id", resp_id, 0);
        check("rst_mask", resp_mask, 0);
        check("rst_eq", resp_eq, 0);
        m_phase = 0;
        m_prio  = 0;
      end else if (m_phase == 0) begin
        exp_r0 = req0_valid && (!req1_valid || !m_prio);
        exp_r1 = req1_valid && (!req0_valid || m_prio);
        check("idle_r0", req0_ready, exp_r0);
        check("idle_r1", req1_ready, exp_r1);
        check("idle_valid", resp_valid, 0);
        check("idle_busy", busy, 0);
        if (exp_r0 || exp_r1) begin
          m_id    = exp_r1;
          m_mask  = exp_r1 ? ~(req1_a ^ req1_b) : ~(req0_a ^ req0_b);
          m_prio  = !exp_r1;
          m_left  = WIDTH;
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        check("cmp_r0", req0_ready, 0);
        check("cmp_r1", req1_ready, 0);
        check("cmp_valid", resp_valid, 0);
        check("cmp_busy", busy, 1);
        m_left--;
        if (m_left == 0) m_phase = 2;
      end else begin
        check("resp_r0", req0_ready, 0);
        check("resp_r1", req1_ready, 0);
        check("resp_valid", resp_valid, 1);
        check("resp_busy", busy, 1);
        check("resp_id", resp_id, m_id);
        check("resp_mask", resp_mask, m_mask);
        check("resp_eq", resp_eq, (m_mask == 8'hFF));
        if (resp_ready) begin
          log_id.push_back(resp_id);
          log_mask.push_back(resp_mask);
          log_eq.push_back(resp_eq);
          m_phase = 0;
        end
      end
    end
  end

  task automatic wait_ready(input int port, input string nm, output int acc_cyc);
    bit seen = 0;
    acc_cyc = 0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      if ((port == 0) ? req0_ready : req1_ready) begin
        seen    = 1;
        acc_cyc = cyc;
      end
    end
    check(nm, seen, 1);
  endtask

  task automatic wait_log(input int target, input string nm);
    bit done = 0;
    for (int k = 0; k < 120 && !done; k++) begin
      @(posedge clk);
      #1;
      if (log_id.size() >= target) done = 1;
    end
    check(nm, done, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_cyc, rv_cyc;
    bit found;
    logic [7:0] s_mask;
    bit s_id;
    bit exp_ids[8] = '{1, 0, 1, 0, 1, 0, 0, 1};
    logic [7:0] exp_masks[8] = '{8'hEF, 8'h00, 8'hFE, 8'h00, 8'hFE, 8'hFF, 8'h00, 8'h7F};

    rst_n = 0; req0_valid = 0; req1_valid = 0; resp_ready = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;

    // Reset held with random inputs
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      req0_valid = 1'($urandom); req1_valid = 1'($urandom); resp_ready = 1'($urandom);
      req0_a = 8'($urandom); req0_b = 8'($urandom); req1_a = 8'($urandom); req1_b = 8'($urandom);
      #1;
      check("rst_hold_r0", req0_ready, 0);
      check("rst_hold_r1", req1_ready, 0);
    end

    // Release with only requester 1 valid: single-bit mismatch
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 1; req1_a = 8'h0F; req1_b = 8'h1F; resp_ready = 1; rst_n = 1;
    #1;
    check("release_r1_ready", req1_ready, 1);
    wait_ready(1, "acc_r1_first", acc_cyc);
    @(posedge clk); #1; req1_valid = 0;
    wait_log(1, "resp_r1_first");

    // Arbitration: both valid continuously, four grants
    req0_valid = 1; req0_a = 8'h3C; req0_b = 8'hC3;
    req1_valid = 1; req1_a = 8'h55; req1_b = 8'h54;
    wait_log(5, "arb_four_resps");
    req0_valid = 0; req1_valid = 0;

    // Equal words with latency check
    req0_valid = 1; req0_a = 8'hA5; req0_b = 8'hA5;
    wait_ready(0, "acc_eq", acc_cyc);
    @(posedge clk); #1; req0_valid = 0;
    found = 0; rv_cyc = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (resp_valid) begin found = 1; rv_cyc = cyc; end
    end
    check("eq_resp_seen", found, 1);
    check("eq_latency", rv_cyc - acc_cyc, 9);
    wait_log(6, "resp_eq_word");

    // All bits differ
    @(posedge clk); #1;
    req0_valid = 1; req0_a = 8'h00; req0_b = 8'hFF;
    wait_ready(0, "acc_diff", acc_cyc);
    @(posedge clk); #1; req0_valid = 0;
    wait_log(7, "resp_diff");

    // Backpressure, with requester 0 waiting behind it
    resp_ready = 0;
    req1_valid = 1; req1_a = 8'h81; req1_b = 8'h01;
    wait_ready(1, "acc_bp", acc_cyc);
    @(posedge clk); #1;
    req1_valid = 0; req0_valid = 1; req0_a = 8'h12; req0_b = 8'h12;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (resp_valid) found = 1;
    end
    check("bp_resp_seen", found, 1);
    s_mask = resp_mask; s_id = resp_id;
    check("bp_mask_lit", s_mask, 8'h7F);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_hold_valid", resp_valid, 1);
      check("bp_hold_mask", resp_mask, s_mask);
      check("bp_hold_id", resp_id, s_id);
      check("bp_hold_busy", busy, 1);
      check("bp_hold_r0", req0_ready, 0);
    end
    @(posedge clk); #1; resp_ready = 1;
    @(negedge clk);
    @(negedge clk);
    check("bp_idle_next_r0", req0_ready, 1);
    @(posedge clk); #1; req0_valid = 0;

    // Reset during the fourth SHIFT cycle
    @(posedge clk); @(posedge clk); @(posedge clk);
    #2; rst_n = 0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_valid", resp_valid, 0);
    check("midrst_mask", resp_mask, 0);
    check("midrst_id", resp_id, 0);
    @(posedge clk); @(posedge clk); #1; rst_n = 1;
    repeat (20) @(posedge clk);
    #1;
    check("midrst_no_resp", log_id.size(), 8);
    req0_valid = 1; req1_valid = 1;
    #1;
    check("midrst_prio_r0", req0_ready, 1);
    check("midrst_prio_r1", req1_ready, 0);
    #1; req0_valid = 0; req1_valid = 0;

    // Pin the model with hand-computed response sequence
    check("log_count", log_id.size(), 8);
    if (log_id.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check($sformatf("log_id_%0d", i), log_id[i], exp_ids[i]);
        check($sformatf("log_mask_%0d", i), log_mask[i], exp_masks[i]);
        check($sformatf("log_eq_%0d", i), log_eq[i], (i == 5));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xnor_compare_sched.md
# xnor_compare_sched

Scheduler that shares a single 1-bit XNOR equality cell (NAND-only structure) between two requesters to compare WIDTH-bit word pairs bit-serially. It arbitrates round-robin between the two request ports and sequences the cell over WIDTH cycles. It returns a per-bit match mask plus a word-equal flag on a valid/ready response port. It sits between requesting logic and the shared comparison cell, replacing WIDTH parallel XNOR cells with one cell plus control.

## Interface
- WIDTH, 8, word width compared per request (≥2)
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req0_valid  input  1  requester 0 has a word pair
- req0_a, req0_b  input  WIDTH  requester 0 operands
- req0_ready  output  1  requester 0 accepted this cycle
- req1_valid  input  1  requester 1 has a word pair
- req1_a, req1_b  input  WIDTH  requester 1 operands
- req1_ready  output  1  requester 1 accepted this cycle
- resp_valid  output  1  response held stable
- resp_ready  input  1  consumer takes response
- resp_id  output  1  requester served (0/1)
- resp_mask  output  WIDTH  bit i = ~(a[i]^b[i])
- resp_eq  output  1  1 iff resp_mask is all ones
- busy  output  1  state ≠ IDLE

## Operation
- Comparison cell: one instance, computed only as NAND gates: na=~(x&x), nb=~(y&y), y=~(~(x&y) & ~(na&nb)). No other XNOR/XOR logic on the datapath.
- States: IDLE, SHIFT, RESP.
- IDLE: reqN_ready is combinational: 1 only for the granted requester when it is valid. Grant rule: if only one is valid, grant it; if both are valid, grant the one named by the priority pointer `prio`. On acceptance: latch a and b into shift registers, set resp_id=grant, clear mask, set bit counter to 0, set prio to the other requester, go to SHIFT.
- SHIFT: each cycle, feed a_sh[0] and b_sh[0] to the cell. Write the cell output to mask[cnt]. Shift a_sh and b_sh right by 1. Increment cnt. When the cycle with cnt==WIDTH-1 completes, go to RESP.
- RESP: resp_valid=1. resp_mask, resp_eq and resp_id are stable. Both reqN_ready are 0. On resp_valid&&resp_ready, go to IDLE. No new request is accepted in that same cycle.
- resp_eq = AND-reduce of resp_mask. It is registered or derived from registered mask; it is never combinational from inputs.
- Operand inputs are don't-care after the acceptance edge.
- Counter width: $clog2(WIDTH). It must not overflow at WIDTH a power of two.

## Timing
- Reset (async assert, any state): state=IDLE, prio=0, cnt=0, resp_valid=0, resp_id=0, resp_mask=0, resp_eq=0, busy=0. The reqN_ready outputs follow the IDLE rule once reset deasserts.
- Reset mid-SHIFT or mid-RESP: the in-flight request is dropped and no response is produced.
- Acceptance at edge T. SHIFT occupies edges T+1..T+WIDTH. resp_valid=1 from after edge T+WIDTH.
- Minimum request-to-response latency: WIDTH+1 cycles. Throughput: one request per WIDTH+2 cycles (accept, WIDTH shifts, ≥1 RESP cycle).
- Backpressure: while resp_ready=0, RESP holds indefinitely with all resp_* unchanged, and both ready outputs stay 0.
- busy=1 from the cycle after acceptance until the response handshake completes.
- Simultaneous valid in IDLE: only one ready is asserted. The loser must keep its valid and operands stable until it is accepted.
- prio updates only on acceptance, not on idle cycles.

## Test plan
- Reset: hold rst_n=0 with random inputs -> all outputs 0. Release with req1_valid=1 alone -> req1_ready=1 in the first IDLE cycle.
- Equal words: WIDTH=8, req0 a=0xA5 b=0xA5 -> resp_valid 9 cycles after acceptance with resp_id=0, resp_mask=0xFF, resp_eq=1.
- Single-bit mismatch: req1 a=0x0F b=0x1F -> resp_id=1, resp_mask=0xEF, resp_eq=0. Also a=0x00 b=0xFF -> mask=0x00.
- Arbitration: both valid continuously with different operands -> grants alternate 0,1,0,1 starting at 0 after reset. No requester is served twice in a row while the other is waiting.
- Backpressure: resp_ready=0 for 5 cycles in RESP -> resp_* stable, busy=1, no reqN_ready. On resp_ready=1 -> IDLE next cycle, then the next acceptance.
- Reset mid-operation: assert rst_n=0 at SHIFT cycle 4 -> outputs 0 immediately. After release, the dropped request produces no response and prio=0.
